// File: rtl/to_lower_stream.sv
// Streaming ASCII upper-to-lower converter with a small output FIFO
// and saturating statistics counters for accepted and modified bytes.
module to_lower_stream #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     clr_counts,
  output logic [CNT_W-1:0]         byte_count,
  output logic [CNT_W-1:0]         conv_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t          state, next_state;
  logic [LW-1:0]   level_next;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      mem [DEPTH];
  logic            push, pop;
  logic            is_upper, do_conv;
  logic [7:0]      stored;

  // Handshakes depend only on registered state, so out_ready never reaches in_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign is_upper = (in_data >= 8'h41) && (in_data <= 8'h5A);
  assign do_conv  = en & is_upper;
  assign stored   = do_conv ? (in_data | 8'h20) : in_data;

  always_comb begin
    level_next = level;
    next_state = state;
    if (push && !pop)
      level_next = level + LW'(1);
    else if (pop && !push)
      level_next = level - LW'(1);
    if (level_next == '0)
      next_state = EMPTY;
    else if (level_next == LW'(DEPTH))
      next_state = FULL;
    else
      next_state = PARTIAL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= next_state;
      level <= level_next;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage is cleared on reset so out_data reads 0x00 until the first write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 8'h00;
    end else if (push) begin
      mem[wr_ptr] <= stored;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_count <= '0;
      conv_count <= '0;
    end else if (clr_counts) begin
      byte_count <= '0;
      conv_count <= '0;
    end else if (push) begin
      if (byte_count != '1)
        byte_count <= byte_count + CNT_W'(1);
      if (do_conv && (conv_count != '1))
        conv_count <= conv_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_to_lower_stream.sv
// Randomized and directed bench for to_lower_stream, checked against a
// queue-based reference model of the converter, FIFO and counters.
module tb_to_lower_stream;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   clr_counts;
  logic [CNT_W-1:0]       byte_count;
  logic [CNT_W-1:0]       conv_count;
  logic [$clog2(DEPTH):0] level;

  int checks   = 0;
  int failures = 0;

  byte unsigned mq[$];
  int           exp_bytes = 0;
  int           exp_conv  = 0;

  to_lower_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .clr_counts (clr_counts),
    .byte_count (byte_count),
    .conv_count (conv_count),
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("level", 32'(level), 32'(mq.size()));
    checkOutput("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    checkOutput("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0)
      checkOutput("out_data", 32'(out_data), 32'(mq[0]));
    checkOutput("byte_count", 32'(byte_count), 32'(exp_bytes));
    checkOutput("conv_count", 32'(conv_count), 32'(exp_conv));
  endtask

  // One clock of stimulus; the model advances at the edge, DUT is checked at the following negedge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic e,
                               input logic r, input logic c);
    bit           do_push, do_pop;
    byte unsigned sd;
    byte unsigned dropped;
    in_valid   = v;
    in_data    = d;
    en         = e;
    out_ready  = r;
    clr_counts = c;
    @(posedge clk);
    do_push = v && (mq.size() < DEPTH);
    do_pop  = r && (mq.size() > 0);
    if (do_pop)
      dropped = mq.pop_front();
    if (do_push) begin
      sd = d;
      if (e && d >= "A" && d <= "Z")
        sd = d + 8'd32;
      mq.push_back(sd);
      if (exp_bytes < CNT_MAX)
        exp_bytes++;
      if (sd != d && exp_conv < CNT_MAX)
        exp_conv++;
    end
    if (c) begin
      exp_bytes = 0;
      exp_conv  = 0;
    end
    @(negedge clk);
    checkModel();
  endtask

  task automatic drain();
    repeat (DEPTH + 1) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] hello [8];
    logic [7:0] raw [3];
    logic [7:0] rd;
    hello = '{8'h48, 8'h65, 8'h4C, 8'h4C, 8'h6F, 8'h5B, 8'h40, 8'h5A};
    raw   = '{8'h41, 8'h5A, 8'hC1};

    rst = 1'b1; en = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    out_ready = 1'b0; clr_counts = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_data", 32'(out_data), 32'h00);
    checkModel();
    rst = 1'b0;

    $display("[TB] mixed-case string with en=1");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, hello[i], 1'b1, 1'b1, 1'b0);
    drain();
    checkOutput("hello_bytes", 32'(byte_count), 32'd8);
    checkOutput("hello_conv", 32'(conv_count), 32'd4);

    $display("[TB] pass-through with en=0");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, raw[i], 1'b0, 1'b1, 1'b0);
    drain();
    checkOutput("raw_conv", 32'(conv_count), 32'd0);

    $display("[TB] fill to full, then release");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 8'h30 + 8'(i), 1'b1, 1'b0, 1'b0);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("full_level", 32'(level), 32'd4);
    applyStimulus(1'b1, 8'h34, 1'b1, 1'b1, 1'b0);
    checkOutput("full_pop_level", 32'(level), 32'd3);
    applyStimulus(1'b1, 8'h34, 1'b1, 1'b1, 1'b0);
    drain();

    $display("[TB] steady push/pop at level 2");
    applyStimulus(1'b1, 8'h61, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'h43 + 8'(i), 1'b1, 1'b1, 1'b0);
      checkOutput("steady_level", 32'(level), 32'd2);
    end
    drain();

    $display("[TB] counter saturation and clear");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 8'h41, 1'b1, 1'b1, 1'b0);
    checkOutput("sat_bytes", 32'(byte_count), 32'(CNT_MAX));
    checkOutput("sat_conv", 32'(conv_count), 32'(CNT_MAX));
    applyStimulus(1'b1, 8'h41, 1'b1, 1'b1, 1'b1);
    checkOutput("clr_bytes", 32'(byte_count), 32'd0);
    checkOutput("clr_conv", 32'(conv_count), 32'd0);
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       rd = 8'($urandom_range(8'h40, 8'h5B));
        1:       rd = 8'($urandom_range(8'h60, 8'h7B));
        default: rd = 8'($urandom_range(0, 255));
      endcase
      applyStimulus(1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0));
    end
    drain();

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 8'h4B + 8'(i), 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    mq.delete();
    exp_bytes = 0;
    exp_conv  = 0;
    checkModel();
    checkOutput("arst_out_data", 32'(out_data), 32'h00);
    #1 rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 8'h51, 1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_data", 32'(out_data), 32'h71);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
